// File: rtl/accum_cpu_core.sv
// Multi-cycle accumulator CPU core with parametrised widths,
// carry flag E and a req/ack memory port that tolerates wait states.
module accum_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ac,
    output logic [ADDR_W-1:0] pc,
    output logic              e_flag,
    output logic [2:0]        sc,
    output logic              halted
);

    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        DEC  = 3'd2,
        IND  = 3'd3,
        OPRD = 3'd4,
        EXE  = 3'd5,
        STR  = 3'd6,
        HALT = 3'd7
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] dr;
    logic [2:0]        opc;
    logic              ind;
    logic [DATA_W:0]   sum;
    logic              ir_unused;

    assign opc = ir[DATA_W-2:DATA_W-4];
    assign ind = ir[DATA_W-1];
    // Bits between the opcode and address fields carry no meaning.
    assign ir_unused = ^ir;

    // Memory port and status are pure decodes of the state register.
    assign mem_req   = (state == F1) || (state == IND) ||
                       (state == OPRD) || (state == STR);
    assign mem_we    = (state == STR);
    assign mem_addr  = ar;
    assign mem_wdata = ac;
    assign sc        = state;
    assign halted    = (state == HALT);

    always_comb begin
        sum = {1'b0, ac} + {1'b0, ac};
        unique case (1'b1)
            opc == OP_ADD: sum = {1'b0, ac} + {1'b0, dr};
            opc == OP_SUB: sum = {1'b0, ac} + {1'b0, ~dr} + ONE;
            default:       sum = {1'b0, ac} + {1'b0, ac};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= F0;
            ac     <= '0;
            pc     <= '0;
            ar     <= '0;
            ir     <= '0;
            dr     <= '0;
            e_flag <= 1'b0;
        end else begin
            unique case (state)
                F0: begin
                    ar    <= pc;
                    state <= F1;
                end
                F1: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= DEC;
                    end
                end
                DEC: begin
                    ar <= ir[ADDR_W-1:0];
                    unique case (1'b1)
                        opc == OP_HLT:                  state <= HALT;
                        opc == OP_SHL || opc == OP_CMA: state <= EXE;
                        ind:                            state <= IND;
                        opc == OP_STA:                  state <= STR;
                        default:                        state <= OPRD;
                    endcase
                end
                IND: begin
                    if (mem_ack) begin
                        ar    <= mem_rdata[ADDR_W-1:0];
                        state <= (opc == OP_STA) ? STR : OPRD;
                    end
                end
                OPRD: begin
                    if (mem_ack) begin
                        dr    <= mem_rdata;
                        state <= EXE;
                    end
                end
                EXE: begin
                    unique case (1'b1)
                        opc == OP_ADD,
                        opc == OP_SUB,
                        opc == OP_SHL: {e_flag, ac} <= sum;
                        opc == OP_XOR: ac <= ac ^ dr;
                        opc == OP_CMA: ac <= ~ac;
                        opc == OP_LDA: ac <= dr;
                        default: ;
                    endcase
                    state <= F0;
                end
                STR: begin
                    if (mem_ack) state <= F0;
                end
                HALT: ;
                default: state <= F0;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed bench for accum_cpu_core: memory model with
// programmable ack delays, hand-computed expected values.
module tb_accum_cpu_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] ac;
    logic [3:0] pc;
    logic       e_flag;
    logic [2:0] sc;
    logic       halted;

    logic [7:0] mem [16];
    int         wcnt = 0;
    int         rdelay = 0;
    int         wdelay = 0;
    logic       hold_ack = 1'b0;
    int         st_cnt = 0;
    logic [3:0] st_addr = '0;
    logic [7:0] st_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    accum_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ac        (ac),
        .pc        (pc),
        .e_flag    (e_flag),
        .sc        (sc),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && !hold_ack &&
                       (wcnt >= (mem_we ? wdelay : rdelay));

    always @(posedge CLK) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (mem_req && mem_we && mem_ack) begin
            st_cnt  <= st_cnt + 1;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    task automatic fill_hlt();
        for (int i = 0; i < 16; i++) mem[i] = 8'h70;
    endtask

    task automatic load_add_prog();
        fill_hlt();
        mem[0]  = 8'h4A;
        mem[1]  = 8'h0B;
        mem[2]  = 8'h70;
        mem[10] = 8'hF0;
        mem[11] = 8'h20;
    endtask

    int st_before;

    initial begin
        // Reset in the middle of a stalled fetch
        fill_hlt();
        hold_ack = 1'b1;
        do_reset();
        tick(2);
        check("stall_sc", sc, 3'd1);
        check("stall_req", mem_req, 1'b1);
        RST = 1'b1;
        tick(1);
        check("rst_sc", sc, 3'd0);
        check("rst_req", mem_req, 1'b0);
        check("rst_pc", pc, 4'd0);
        check("rst_ac", ac, 8'd0);
        check("rst_e", e_flag, 1'b0);
        check("rst_halt", halted, 1'b0);
        tick(1);
        RST = 1'b0;
        hold_ack = 1'b0;

        // LDA 0xF0, ADD 0x20 -> 0x110, then HLT at cycle 13
        load_add_prog();
        do_reset();
        tick(12);
        check("add_halt12", halted, 1'b0);
        tick(1);
        check("add_halt13", halted, 1'b1);
        check("add_ac", ac, 8'h10);
        check("add_e", e_flag, 1'b1);
        check("add_pc", pc, 4'd3);
        check("add_sc", sc, 3'd7);
        tick(3);
        check("add_stay", halted, 1'b1);

        // Same program with one read wait state each access
        rdelay = 1;
        do_reset();
        tick(17);
        check("wait_halt17", halted, 1'b0);
        tick(1);
        check("wait_halt18", halted, 1'b1);
        check("wait_ac", ac, 8'h10);
        rdelay = 0;

        // LDA 5, SUB 7 (borrow), SHL, XOR 0x0F, HLT
        fill_hlt();
        mem[0]  = 8'h48;
        mem[1]  = 8'h19;
        mem[2]  = 8'h30;
        mem[3]  = 8'h2A;
        mem[4]  = 8'h70;
        mem[8]  = 8'h05;
        mem[9]  = 8'h07;
        mem[10] = 8'h0F;
        do_reset();
        tick(5);
        check("lda_ac", ac, 8'h05);
        tick(5);
        check("sub_ac", ac, 8'hFE);
        check("sub_e", e_flag, 1'b0);
        tick(4);
        check("shl_ac", ac, 8'hFC);
        check("shl_e", e_flag, 1'b1);
        tick(5);
        check("xor_ac", ac, 8'hF3);
        check("xor_e", e_flag, 1'b1);
        tick(3);
        check("sub_halt", halted, 1'b1);

        // Indirect LDA through mem[12]
        fill_hlt();
        mem[0]  = 8'hCC;
        mem[12] = 8'h0D;
        mem[13] = 8'h5A;
        do_reset();
        tick(3);
        check("ind_sc", sc, 3'd3);
        check("ind_addr", mem_addr, 4'hC);
        tick(1);
        check("ind_oprd_sc", sc, 3'd4);
        check("ind_ar", mem_addr, 4'hD);
        tick(1);
        check("ind_exe_sc", sc, 3'd5);
        tick(1);
        check("ind_ac", ac, 8'h5A);
        check("ind_f0", sc, 3'd0);

        // LDA 0x3C then STA 14 with three write wait states
        fill_hlt();
        mem[0]  = 8'h4A;
        mem[1]  = 8'h5E;
        mem[10] = 8'h3C;
        wdelay = 3;
        st_before = st_cnt;
        do_reset();
        tick(7);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("str_sc%0d", i), sc, 3'd6);
            check($sformatf("str_req%0d", i),
                  {mem_req, mem_we}, 2'b11);
            check($sformatf("str_addr%0d", i), mem_addr, 4'hE);
            check($sformatf("str_wd%0d", i), mem_wdata, 8'h3C);
        end
        tick(1);
        check("str_next", sc, 3'd0);
        check("str_cnt", st_cnt - st_before, 1);
        check("str_waddr", st_addr, 4'hE);
        check("str_wdata", st_data, 8'h3C);
        wdelay = 0;

        // Sixteen CMAs wrap the PC back to zero
        for (int i = 0; i < 16; i++) mem[i] = 8'h60;
        do_reset();
        tick(4);
        check("cma1_ac", ac, 8'hFF);
        check("cma1_pc", pc, 4'd1);
        tick(60);
        check("wrap_pc", pc, 4'd0);
        check("wrap_ac", ac, 8'h00);
        check("wrap_sc", sc, 3'd0);
        tick(1);
        check("wrap_fetch", mem_addr, 4'd0);
        tick(3);
        check("wrap_ac2", ac, 8'hFF);
        check("wrap_pc2", pc, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accum_cpu_core.md
Name: accum_cpu_core

Overview:
Parametrised multi-cycle accumulator CPU core. It is the successor to the fixed 8-bit/16-word sequencer, with configurable data and address widths and a req/ack memory port that tolerates wait states. It adds carry flag E, store and load instructions, halt, and a defined synchronous reset. It sits between the program/data memory model and the top-level testbench, and embeds the ALU operation set add/sub/xor/shl/cmp.

Parameters:
DATA_W, 8, word and accumulator width; must satisfy DATA_W >= ADDR_W+4
ADDR_W, 4, memory address width; PC and AR width; memory depth 2^ADDR_W

Ports:
CLK  in  1  clock, all state changes on rising edge
RST  in  1  synchronous active-high reset
mem_req  out  1  memory access request; Moore output of state
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  access address (= AR)
mem_wdata  out  DATA_W  write data (= AC)
mem_rdata  in  DATA_W  read data; sampled on the edge where mem_ack=1
mem_ack  in  1  access complete; ignored when mem_req=0
ac  out  DATA_W  accumulator
pc  out  ADDR_W  program counter
e_flag  out  1  carry/borrow flag E
sc  out  3  current state code
halted  out  1  1 while in HALT

Behaviour:
- Instruction format: IR[DATA_W-1]=I (indirect); IR[DATA_W-2:DATA_W-4]=opcode; IR[ADDR_W-1:0]=address. Any remaining bits are ignored.
- Opcodes: 000 ADD, 001 SUB, 010 XOR, 011 SHL (AC+AC), 100 LDA, 101 STA, 110 CMA (~AC), 111 HLT.
- Reset (RST=1 at an edge): AC=0, PC=0, AR=0, IR=0, DR=0, E=0, state=F0 (sc=0), halted=0. Because mem_req is a Moore output of state, it is 0 from the cycle after the reset edge.
- Reset has priority over every other event. A reset mid-transaction abandons the transaction; any late mem_ack is ignored.
- States and sc codes: F0=0, F1=1, DEC=2, IND=3, OPRD=4, EXE=5, STR=6, HALT=7.
- F0: AR<=PC; go to F1.
- F1: mem_req=1, mem_we=0. Stay in F1 while mem_ack=0. On ack: IR<=mem_rdata, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0); go to DEC.
- DEC: AR<=IR address field, then branch on opcode:
  - HLT: go to HALT.
  - SHL or CMA: go to EXE; the I bit is ignored.
  - Memory ops with I=1: go to IND.
  - STA with I=0: go to STR.
  - Other ops with I=0: go to OPRD.
- IND: read at AR, waiting on ack. On ack: AR<=mem_rdata[ADDR_W-1:0]; go to STR for STA, otherwise OPRD. Indirection is single-level.
- OPRD: read at AR, waiting on ack. On ack: DR<=mem_rdata; go to EXE.
- EXE (one cycle, then F0):
  - ADD: {E,AC}<=AC+DR, computed at DATA_W+1 bits.
  - SUB: {E,AC}<=AC+~DR+1, so E=1 means no borrow.
  - XOR: AC<=AC^DR; E unchanged.
  - SHL: {E,AC}<=AC+AC, so E=old AC msb.
  - CMA: AC<=~AC; E unchanged.
  - LDA: AC<=DR; E unchanged.
- STR: mem_req=1, mem_we=1, mem_wdata=AC, mem_addr=AR. Wait for ack, then go to F0.
- HALT: halted=1, mem_req=0. Left only by RST.
- While mem_req=1, mem_addr, mem_we and mem_wdata are held stable until the ack edge. mem_req may stay high across consecutive access states.
- Latency with mem_ack tied to 1 (each wait cycle adds 1):
  - Direct ADD/SUB/XOR/LDA: 5 cycles.
  - Direct STA: 4 cycles.
  - SHL/CMA: 4 cycles.
  - Indirect memory op: +1 cycle.
  - HLT: 3 cycles to reach HALT.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=4.
- Reset: hold RST 2 cycles mid-F1 with mem_ack=0 -> sc=0, pc=0, ac=0, e_flag=0, mem_req=0 one cycle after reset edge, halted=0.
- Load/add/carry: mem[0]=0x4A, mem[1]=0x0B, mem[2]=0x70, mem[10]=0xF0, mem[11]=0x20, ack tied 1 -> ac=0x10, e_flag=1, halted=1 at cycle 13, pc=3.
- SUB borrow and SHL: program sets AC=0x05 via LDA, then SUB of 0x07 -> ac=0xFE, e_flag=0. Then SHL -> ac=0xFC, e_flag=1.
- Indirect: LDA 0xCC with mem[12]=0x0D, mem[13]=0x5A -> IND visited (sc=3), AR=0xD, ac=0x5A, 6 cycles.
- Store with wait states: STA 0x5E, ack delayed 3 cycles -> mem_req/mem_we=1, mem_addr=0xE and mem_wdata=AC stable all 4 STR cycles; mem[14]=AC; next state F0.
- PC wrap: all 16 words CMA (0x60) -> after 16 instructions pc=0 and ac=~ac^16 (ac=0x00); execution continues at address 0.
